uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning i_tick pulses per bit period; even, 8..32.
REQ-003 SHALL have parameter PARITY_MODE, default 0, meaning parity type: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame: 1 or 2.
REQ-005 SHALL have port i_clk  input  1  meaning the single clock; all state on rising edge.
REQ-006 SHALL have port i_rst  input  1  meaning asynchronous, active-low reset.
REQ-007 SHALL have port i_tick  input  1  meaning one-cycle oversample strobe from the external baud generator.
REQ-008 SHALL have port i_rx  input  1  meaning asynchronous serial line, idle high.
REQ-009 SHALL have port i_rd  input  1  meaning consumer acknowledge; clears o_valid and o_overrun.
REQ-010 SHALL have port o_data  output  DATA_BITS  meaning last received word, LSB received first.
REQ-011 SHALL have port o_valid  output  1  meaning o_data holds an unread word.
REQ-012 SHALL have port o_parity_err  output  1  meaning parity mismatch on the word in o_data.
REQ-013 SHALL have port o_frame_err  output  1  meaning a stop bit sampled 0 on the word in o_data.
REQ-014 SHALL have port o_overrun  output  1  meaning a word was overwritten before i_rd; sticky.
REQ-015 SHALL have port o_break  output  1  meaning the last frame was all-zero including stop.

Function
REQ-016 SHALL pass i_rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; tick counter and bit counter advance only on i_tick.
REQ-018 IDLE: synchronized rx = 0 SHALL enter START with tick counter cleared.
REQ-019 START: at tick OVERSAMPLE/2-1, rx = 0 SHALL enter DATA; rx = 1 SHALL return to IDLE (glitch reject, no flags).
REQ-020 DATA/PARITY/STOP: each bit SHALL span OVERSAMPLE ticks; bit value = majority of samples at ticks OVERSAMPLE-3, -2, -1.
REQ-021 DATA SHALL shift in DATA_BITS bits LSB first, then go to PARITY if PARITY_MODE != 0, else STOP.
REQ-022 PARITY: error when XOR(data, parity bit) != 0 (even) or != 1 (odd); PARITY_MODE 0 SHALL hold o_parity_err at 0.
REQ-023 STOP: SHALL check STOP_BITS bits; any stop bit 0 SHALL flag frame error.
REQ-024 Break: all data bits 0, parity bit 0 (if present), first stop bit 0 SHALL set o_break together with o_frame_err.
REQ-025 On the clock after the final stop sample, SHALL load o_data, o_parity_err, o_frame_err, o_break and set o_valid (one-cycle latency).
REQ-026 After completion: frame error SHALL enter WAIT_HIGH, else IDLE; WAIT_HIGH SHALL go to IDLE only once synchronized rx = 1.
REQ-027 Completion with o_valid = 1 and i_rd = 0 SHALL overwrite o_data and set o_overrun.
REQ-028 i_rd without completion SHALL clear o_valid and o_overrun next clock; error flags hold until the next completion.
REQ-029 i_rd and completion in the same cycle SHALL keep o_valid = 1 with new data and leave o_overrun = 0.
REQ-030 i_tick = 0 SHALL freeze all counters and FSM except synchronizer, i_rd handling and register load.

Reset
REQ-031 i_rst = 0 SHALL asynchronously force FSM to IDLE, counters to 0 and synchronizer to 1.
REQ-032 During reset, o_data = 0, o_valid = 0, o_parity_err = 0, o_frame_err = 0, o_overrun = 0, o_break = 0.
REQ-033 Reset mid-frame SHALL discard the partial word; no flag or o_valid asserts for it after release.

Verification
REQ-034 Defaults, tick every clock, frame 0x38 (bits 0,0,0,1,1,1,0,0), stop 1 -> o_data = 0x38, o_valid = 1, all flags 0.
REQ-035 Low pulse of 4 ticks on idle line -> FSM back to IDLE, o_valid stays 0.
REQ-036 PARITY_MODE 1, word 0x07 with parity bit 0 -> o_data = 0x07, o_parity_err = 1; parity bit 1 -> o_parity_err = 0.
REQ-037 Line held low 12 bit periods -> o_data = 0x00, o_frame_err = 1, o_break = 1; no new frame until line returns high.
REQ-038 Frames 0x55 then 0xAA without i_rd -> o_data = 0xAA, o_overrun = 1; i_rd pulse -> o_valid = 0, o_overrun = 0.
REQ-039 Reset asserted during bit 4 of 0xC3, released, then 0x5A sent -> o_data = 0x5A, flags 0, exactly one o_valid rise.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Receiver-side signal bundle: oversample strobe, serial line, read ack and the received word
// with its status flags.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic                 i_tick;
    logic                 i_rx;
    logic                 i_rd;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_parity_err;
    logic                 o_frame_err;
    logic                 o_overrun;
    logic                 o_break;

    modport master (
        output i_tick, i_rx, i_rd,
        input  o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_break
    );

    modport slave (
        input  i_tick, i_rx, i_rd,
        output o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_break
    );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: configurable data bits, parity and stop bits, 3-sample majority
// vote per bit, break detection and sticky overrun.
module uart_rx_param #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    uart_rx_param_if.slave bus
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HalfLast = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BitLast  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] Samp1    = TW'(OVERSAMPLE - 3);
    localparam logic [TW-1:0] Samp2    = TW'(OVERSAMPLE - 2);
    localparam logic [3:0]    DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]    StopLast = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StWaitHigh
    } state_e;

    state_e               state_q, state_d;
    logic                 meta_q, rx_q;
    logic [TW-1:0]        tick_q, tick_d;
    logic [3:0]           bit_q, bit_d;
    logic                 s1_q, s1_d, s2_q, s2_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 stop0_q, stop0_d;
    logic                 ferr_acc_q, ferr_acc_d;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, perr_q, ferr_q, ovr_q, brk_q;

    logic tick, in_bit, bit_end, complete, maj;
    logic frame_err_now, first_stop_zero, par_xor, perr_calc, brk_calc;

    assign tick = bus.i_tick;
    // Third vote is the live synchronized sample taken on the final tick of the bit.
    assign maj  = (s1_q & s2_q) | (s1_q & rx_q) | (s2_q & rx_q);

    assign frame_err_now   = ferr_acc_q | ~maj;
    assign first_stop_zero = (bit_q == 4'd0) ? ~maj : stop0_q;
    assign par_xor         = (^shift_q) ^ par_q;
    assign perr_calc       = (PARITY_MODE == 1) ? par_xor  :
                             (PARITY_MODE == 2) ? ~par_xor : 1'b0;
    assign brk_calc        = ~(|shift_q) && ((PARITY_MODE == 0) || !par_q) && first_stop_zero;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            meta_q <= 1'b1;
            rx_q   <= 1'b1;
        end else begin
            meta_q <= bus.i_rx;
            rx_q   <= meta_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                StIdle:     if (!rx_q) state_d = StStart;
                StStart:    if (tick_q == HalfLast) state_d = rx_q ? StIdle : StData;
                StData: begin
                    if (bit_end && bit_q == DataLast) begin
                        state_d = (PARITY_MODE != 0) ? StParity : StStop;
                    end
                end
                StParity:   if (bit_end) state_d = StStop;
                StStop: begin
                    if (complete) state_d = frame_err_now ? StWaitHigh : StIdle;
                end
                StWaitHigh: if (rx_q) state_d = StIdle;
                default:    state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        in_bit   = (state_q == StData) || (state_q == StParity) || (state_q == StStop);
        bit_end  = tick && in_bit && (tick_q == BitLast);
        complete = bit_end && (state_q == StStop) && (bit_q == StopLast);
    end

    always_comb begin
        tick_d     = tick_q;
        bit_d      = bit_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop0_d    = stop0_q;
        ferr_acc_d = ferr_acc_q;
        if (tick) begin
            case (state_q)
                StIdle: begin
                    tick_d     = '0;
                    bit_d      = '0;
                    ferr_acc_d = 1'b0;
                end
                StStart: tick_d = (tick_q == HalfLast) ? '0 : tick_q + 1'b1;
                StData, StParity, StStop: begin
                    tick_d = bit_end ? '0 : tick_q + 1'b1;
                    if (tick_q == Samp1) s1_d = rx_q;
                    if (tick_q == Samp2) s2_d = rx_q;
                    if (bit_end) begin
                        if (state_q == StData) begin
                            shift_d = {maj, shift_q[DATA_BITS-1:1]};
                            bit_d   = (bit_q == DataLast) ? 4'd0 : bit_q + 4'd1;
                        end else if (state_q == StParity) begin
                            par_d = maj;
                        end else begin
                            if (bit_q == 4'd0) stop0_d = ~maj;
                            ferr_acc_d = frame_err_now;
                            bit_d      = bit_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tick_q     <= '0;
            bit_q      <= '0;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop0_q    <= 1'b0;
            ferr_acc_q <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop0_q    <= stop0_d;
            ferr_acc_q <= ferr_acc_d;
        end
    end

    // A read landing on the completion cycle consumes the old word, so no overrun.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else if (complete) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            perr_q  <= perr_calc;
            ferr_q  <= frame_err_now;
            brk_q   <= brk_calc;
            if (bus.i_rd) begin
                ovr_q <= 1'b0;
            end else if (valid_q) begin
                ovr_q <= 1'b1;
            end
        end else if (bus.i_rd) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_parity_err = perr_q;
    assign bus.o_frame_err  = ferr_q;
    assign bus.o_overrun    = ovr_q;
    assign bus.o_break      = brk_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one default receiver and one even-parity receiver,
// expected words queued as frames are sent and checked once each frame has been received.
module tb_uart_rx_param;

    localparam int Os = 16;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        logic       ovr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   rises_a = 0;
    int   rises_b = 0;
    int   base;
    logic pv_a = 1'b0;
    logic pv_b = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_param_if #(.DATA_BITS(8)) bus_b ();

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)
    ) dut_a (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus_a)
    );

    uart_rx_param #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)
    ) dut_b (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus_b)
    );

    always @(negedge clk) begin
        if (bus_a.o_valid && !pv_a) rises_a++;
        if (bus_b.o_valid && !pv_b) rises_b++;
        pv_a = bus_a.o_valid;
        pv_b = bus_b.o_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) bus_a.i_rx = v;
        else bus_b.i_rx = v;
    endtask

    task automatic hold_bits(input int sel, input logic v, input int n);
        set_rx(sel, v);
        wait_clks(n * Os);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop_v);
        hold_bits(sel, 1'b0, 1);
        for (int i = 0; i < 8; i++) hold_bits(sel, d[i], 1);
        if (has_par) hold_bits(sel, par, 1);
        hold_bits(sel, stop_v, 1);
        set_rx(sel, 1'b1);
        wait_clks(2);
    endtask

    task automatic push(input logic [7:0] d, input logic p, input logic f, input logic b,
                        input logic o);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        e.brk  = b;
        e.ovr  = o;
        sb.push_back(e);
    endtask

    task automatic pulse_rd(input int sel);
        if (sel == 0) bus_a.i_rd = 1'b1;
        else bus_b.i_rd = 1'b1;
        wait_clks(1);
        bus_a.i_rd = 1'b0;
        bus_b.i_rd = 1'b0;
        wait_clks(1);
    endtask

    task automatic check_frame(input int sel, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=no expected entry required=one queued word", tag);
        end else begin
            e = sb.pop_front();
            if (sel == 0) begin
                chk({tag, "_data"}, bus_a.o_data, e.data);
                chk({tag, "_valid"}, bus_a.o_valid, 1'b1);
                chk({tag, "_perr"}, bus_a.o_parity_err, e.perr);
                chk({tag, "_ferr"}, bus_a.o_frame_err, e.ferr);
                chk({tag, "_brk"}, bus_a.o_break, e.brk);
                chk({tag, "_ovr"}, bus_a.o_overrun, e.ovr);
            end else begin
                chk({tag, "_data"}, bus_b.o_data, e.data);
                chk({tag, "_valid"}, bus_b.o_valid, 1'b1);
                chk({tag, "_perr"}, bus_b.o_parity_err, e.perr);
                chk({tag, "_ferr"}, bus_b.o_frame_err, e.ferr);
                chk({tag, "_brk"}, bus_b.o_break, e.brk);
                chk({tag, "_ovr"}, bus_b.o_overrun, e.ovr);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_a.i_tick = 1'b1;
        bus_a.i_rx   = 1'b1;
        bus_a.i_rd   = 1'b0;
        bus_b.i_tick = 1'b1;
        bus_b.i_rx   = 1'b1;
        bus_b.i_rd   = 1'b0;
        rst_n        = 1'b0;
        wait_clks(3);

        chk("rst_data", bus_a.o_data, 8'h00);
        chk("rst_valid", bus_a.o_valid, 1'b0);
        chk("rst_perr", bus_a.o_parity_err, 1'b0);
        chk("rst_ferr", bus_a.o_frame_err, 1'b0);
        chk("rst_ovr", bus_a.o_overrun, 1'b0);
        chk("rst_brk", bus_a.o_break, 1'b0);
        chk("rst_valid_b", bus_b.o_valid, 1'b0);
        rst_n = 1'b1;
        wait_clks(4);

        // Basic frame on the default receiver.
        push(8'h38, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h38, 1'b0, 1'b0, 1'b1);
        check_frame(0, "f38");
        chk("f38_rises", rises_a, 1);
        pulse_rd(0);
        chk("rd_valid", bus_a.o_valid, 1'b0);

        // Short low glitch must be rejected.
        set_rx(0, 1'b0);
        wait_clks(4);
        set_rx(0, 1'b1);
        wait_clks(3 * Os);
        chk("glitch_valid", bus_a.o_valid, 1'b0);
        chk("glitch_rises", rises_a, 1);

        // Two frames without a read: second overwrites and flags overrun.
        push(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        check_frame(0, "f55");
        push(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1);
        check_frame(0, "fAA");
        pulse_rd(0);
        chk("ovr_rd_valid", bus_a.o_valid, 1'b0);
        chk("ovr_rd_ovr", bus_a.o_overrun, 1'b0);

        // Even parity receiver: 0x07 has odd weight, so parity bit 1 is correct.
        push(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        check_frame(1, "par0");
        pulse_rd(1);
        push(8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        check_frame(1, "par1");
        chk("par_rises", rises_b, 2);

        // Break: line held low, then must wait for the line to go high.
        base = rises_a;
        push(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        hold_bits(0, 1'b0, 12);
        check_frame(0, "brk");
        chk("brk_rises", rises_a, base + 1);
        pulse_rd(0);
        chk("brk_rd_valid", bus_a.o_valid, 1'b0);
        chk("brk_rd_ferr_hold", bus_a.o_frame_err, 1'b1);
        chk("brk_rd_brk_hold", bus_a.o_break, 1'b1);
        hold_bits(0, 1'b0, 10);
        chk("brk_low_rises", rises_a, base + 1);
        set_rx(0, 1'b1);
        wait_clks(3 * Os);
        chk("brk_high_rises", rises_a, base + 1);
        chk("brk_high_valid", bus_a.o_valid, 1'b0);

        // Reset during data bit 4 of 0xC3 drops the partial word.
        base = rises_a;
        hold_bits(0, 1'b0, 1);
        hold_bits(0, 1'b1, 1);
        hold_bits(0, 1'b1, 1);
        hold_bits(0, 1'b0, 1);
        hold_bits(0, 1'b0, 1);
        set_rx(0, 1'b0);
        wait_clks(Os / 2);
        rst_n = 1'b0;
        wait_clks(3);
        chk("mid_rst_valid", bus_a.o_valid, 1'b0);
        set_rx(0, 1'b1);
        rst_n = 1'b1;
        wait_clks(3 * Os);
        chk("post_rst_valid", bus_a.o_valid, 1'b0);
        chk("post_rst_ferr", bus_a.o_frame_err, 1'b0);
        chk("post_rst_rises", rises_a, base);
        push(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        check_frame(0, "f5A");
        chk("f5A_rises", rises_a, base + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
